// File: rtl/calc_pkg.sv
// Shared types and widths for the calculadora sequencer: operand widths,
// FSM encoding and the packed command record stored in the FIFO.
package calc_pkg;

   localparam int LARG     = 8;
   localparam int LARG_COD = 3;
   localparam int CMD_W    = LARG_COD + 2 * LARG + 1;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   typedef struct packed {
      logic [LARG_COD-1:0] codigo;
      logic [LARG-1:0]     a;
      logic [LARG-1:0]     b;
      logic                acc;
   } comando_t;

endpackage

// File: rtl/calculadora_sequenciador_if.sv
// Command and result handshakes between a host and the calculadora sequencer.
interface calculadora_sequenciador_if;
   import calc_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [LARG_COD-1:0] cmd_codigo;
   logic [LARG-1:0]     cmd_A;
   logic [LARG-1:0]     cmd_B;
   logic                cmd_acc;

   logic                res_valid;
   logic                res_ready;
   logic [LARG-1:0]     res_saida;

   modport master (
      output cmd_valid, cmd_codigo, cmd_A, cmd_B, cmd_acc, res_ready,
      input  cmd_ready, res_valid, res_saida
   );

   modport slave (
      input  cmd_valid, cmd_codigo, cmd_A, cmd_B, cmd_acc, res_ready,
      output cmd_ready, res_valid, res_saida
   );

endinterface

// File: rtl/calculadora.sv
// Combinational 8-bit calculator datapath; results wrap to LARG bits.
module calculadora
   import calc_pkg::*;
(
   input  logic [LARG_COD-1:0] codigo,
   input  logic [LARG-1:0]     entrada_A,
   input  logic [LARG-1:0]     entrada_B,
   output logic [LARG-1:0]     saida
);

   always_comb begin
      saida = '0;
      case (codigo)
         3'b000:  saida = entrada_A + entrada_B;
         3'b001:  saida = entrada_A - entrada_B;
         3'b010:  saida = entrada_A & entrada_B;
         3'b011:  saida = entrada_A | entrada_B;
         3'b100:  saida = entrada_A ^ entrada_B;
         3'b101:  saida = ~entrada_A;
         3'b110:  saida = entrada_A << 1;
         default: saida = entrada_A >> 1;
      endcase
   end

endmodule

// File: rtl/calculadora_sequenciador_fila_comandos.sv
// Synchronous command FIFO; full/empty come straight from the registered count,
// so a pop never frees a slot for a push in the same cycle.
module fila_comandos #(
   parameter int PROF = 4,
   parameter int W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [W-1:0]            din,
   output logic [W-1:0]            dout,
   output logic                    cheio,
   output logic                    vazio,
   output logic [$clog2(PROF):0]   count
);

   localparam int PW = $clog2(PROF);

   logic [W-1:0]  mem_q [PROF];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign cheio   = (count_q == (PW+1)'(PROF));
   assign vazio   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !cheio;
   assign pop_ok  = pop && !vazio;

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/calculadora_sequenciador.sv
// Sequencer: buffers commands, runs them one at a time through calculadora,
// and returns each registered result while keeping a chaining accumulator.
module calculadora_sequenciador #(
   parameter int PROF_FILA = 4,
   parameter int LARG      = calc_pkg::LARG
) (
   input  logic                        clk,
   input  logic                        rst,
   calculadora_sequenciador_if.slave   bus,
   input  logic                        acc_limpa,
   output logic [LARG-1:0]             acumulador,
   output logic                        ocupado
);

   localparam int PW = $clog2(PROF_FILA);

   calc_pkg::estado_t  estado_q, estado_d;
   calc_pkg::comando_t cmd_in, head;

   logic [calc_pkg::LARG_COD-1:0] op_codigo_q, op_codigo_d;
   logic [LARG-1:0]               op_a_q, op_a_d;
   logic [LARG-1:0]               op_b_q, op_b_d;
   logic [LARG-1:0]               res_saida_q, res_saida_d;
   logic [LARG-1:0]               acumulador_q, acumulador_d;
   logic                          res_valid_q, res_valid_d;
   logic [LARG-1:0]               saida;
   logic                          pop, cheio, vazio;
   logic [PW:0]                   fila_count;

   assign cmd_in = '{codigo: bus.cmd_codigo, a: bus.cmd_A, b: bus.cmd_B, acc: bus.cmd_acc};

   fila_comandos #(
      .PROF (PROF_FILA),
      .W    (calc_pkg::CMD_W)
   ) u_fila (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cmd_valid && !cheio),
      .pop   (pop),
      .din   (cmd_in),
      .dout  (head),
      .cheio (cheio),
      .vazio (vazio),
      .count (fila_count)
   );

   calculadora u_calc (
      .codigo    (op_codigo_q),
      .entrada_A (op_a_q),
      .entrada_B (op_b_q),
      .saida     (saida)
   );

   assign bus.cmd_ready = !cheio;
   assign bus.res_valid = res_valid_q;
   assign bus.res_saida = res_saida_q;
   assign acumulador    = acumulador_q;
   assign ocupado       = (estado_q != calc_pkg::OCIOSO) || (fila_count != '0);

   // Chained operands read the accumulator before any clear in the same cycle.
   always_comb begin
      estado_d     = estado_q;
      op_codigo_d  = op_codigo_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      res_saida_d  = res_saida_q;
      acumulador_d = acumulador_q;
      res_valid_d  = res_valid_q;
      pop          = 1'b0;
      case (estado_q)
         calc_pkg::OCIOSO: begin
            if (!vazio) begin
               pop      = 1'b1;
               estado_d = calc_pkg::CALCULA;
            end
         end
         calc_pkg::CALCULA: begin
            res_saida_d  = saida;
            acumulador_d = saida;
            res_valid_d  = 1'b1;
            estado_d     = calc_pkg::ENTREGA;
         end
         calc_pkg::ENTREGA: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               if (!vazio) begin
                  pop      = 1'b1;
                  estado_d = calc_pkg::CALCULA;
               end else begin
                  estado_d = calc_pkg::OCIOSO;
               end
            end
         end
         default: estado_d = calc_pkg::OCIOSO;
      endcase
      if (pop) begin
         op_codigo_d = head.codigo;
         op_a_d      = head.acc ? acumulador_q : head.a;
         op_b_d      = head.b;
      end
      if (acc_limpa) acumulador_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q     <= calc_pkg::OCIOSO;
         op_codigo_q  <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         res_saida_q  <= '0;
         acumulador_q <= '0;
         res_valid_q  <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         op_codigo_q  <= op_codigo_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         res_saida_q  <= res_saida_d;
         acumulador_q <= acumulador_d;
         res_valid_q  <= res_valid_d;
      end
   end

endmodule

// File: tb/tb_calculadora_sequenciador.sv
// Scoreboard bench for calculadora_sequenciador: stimulus queues expected
// results, a negedge monitor pops and compares on every result handshake.
module tb_calculadora_sequenciador;

   logic       clk;
   logic       rst;
   logic       acc_limpa;
   logic [7:0] acumulador;
   logic       ocupado;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q [$];

   calculadora_sequenciador_if bus ();

   calculadora_sequenciador #(
      .PROF_FILA (4),
      .LARG      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .acc_limpa  (acc_limpa),
      .acumulador (acumulador),
      .ocupado    (ocupado)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      tests_run++;
      if (atual !== esperado) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, required %0h", nome, atual, esperado);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] codigo, input logic [7:0] a, input logic [7:0] b,
                                input logic acc, input logic [7:0] esperado);
      int espera = 0;
      while (!bus.cmd_ready && espera < 100) begin
         @(posedge clk); #1;
         espera++;
      end
      checkOutput("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid  = 1'b1;
      bus.cmd_codigo = codigo;
      bus.cmd_A      = a;
      bus.cmd_B      = b;
      bus.cmd_acc    = acc;
      exp_q.push_back(esperado);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (ocupado && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("idle_wait", {31'd0, ocupado}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_result: got %0h, required no result", bus.res_saida);
         end else begin
            checkOutput("result_order", {24'd0, bus.res_saida}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   logic [2:0] w_cod [10] = '{3'b000, 3'b101, 3'b001, 3'b111, 3'b010,
                              3'b100, 3'b110, 3'b011, 3'b000, 3'b001};
   logic [7:0] w_a   [10] = '{8'h01, 8'h33, 8'h05, 8'h80, 8'h5A,
                              8'h12, 8'h7F, 8'h40, 8'hFF, 8'h00};
   logic [7:0] w_b   [10] = '{8'h02, 8'h00, 8'h07, 8'h00, 8'h0F,
                              8'h21, 8'h00, 8'h04, 8'h01, 8'h01};
   logic [7:0] w_exp [10] = '{8'h03, 8'hCC, 8'hFE, 8'h40, 8'h0A,
                              8'h33, 8'hFE, 8'h44, 8'h00, 8'hFF};

   initial begin
      rst            = 1'b1;
      acc_limpa      = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_codigo = '0;
      bus.cmd_A      = '0;
      bus.cmd_B      = '0;
      bus.cmd_acc    = 1'b0;
      bus.res_ready  = 1'b0;
      #1;
      checkOutput("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      checkOutput("reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
      checkOutput("reset_res_saida", {24'd0, bus.res_saida}, 32'd0);
      checkOutput("reset_acumulador", {24'd0, acumulador}, 32'd0);
      checkOutput("reset_ocupado", {31'd0, ocupado}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] single command");
      bus.res_ready = 1'b1;
      applyStimulus(3'b001, 8'h12, 8'h34, 1'b0, 8'hDE);
      checkOutput("single_ocupado", {31'd0, ocupado}, 32'd1);
      @(posedge clk); #1;
      checkOutput("single_calc_codigo", {29'd0, dut.u_calc.codigo}, 32'd1);
      checkOutput("single_calc_A", {24'd0, dut.u_calc.entrada_A}, 32'h12);
      checkOutput("single_calc_B", {24'd0, dut.u_calc.entrada_B}, 32'h34);
      checkOutput("single_calc_saida", {24'd0, dut.u_calc.saida}, 32'hDE);
      checkOutput("single_valid_early", {31'd0, bus.res_valid}, 32'd0);
      @(posedge clk); #1;
      checkOutput("single_valid_rise", {31'd0, bus.res_valid}, 32'd1);
      checkOutput("single_res_saida", {24'd0, bus.res_saida}, 32'hDE);
      @(posedge clk); #1;
      checkOutput("single_valid_fall", {31'd0, bus.res_valid}, 32'd0);
      checkOutput("single_acumulador", {24'd0, acumulador}, 32'hDE);
      checkOutput("single_ocupado_fall", {31'd0, ocupado}, 32'd0);

      $display("[TB] chaining");
      applyStimulus(3'b000, 8'h05, 8'h03, 1'b0, 8'h08);
      applyStimulus(3'b000, 8'hFF, 8'h02, 1'b1, 8'h0A);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("chain_calc_A", {24'd0, dut.u_calc.entrada_A}, 32'h08);
      waitIdle();
      checkOutput("chain_acumulador", {24'd0, acumulador}, 32'h0A);

      $display("[TB] acc_limpa collision");
      applyStimulus(3'b010, 8'hF0, 8'h3C, 1'b0, 8'h30);
      @(posedge clk); #1;
      checkOutput("limpa_pre_acumulador", {24'd0, acumulador}, 32'h0A);
      acc_limpa = 1'b1;
      @(posedge clk); #1;
      acc_limpa = 1'b0;
      checkOutput("limpa_acumulador", {24'd0, acumulador}, 32'd0);
      checkOutput("limpa_res_saida", {24'd0, bus.res_saida}, 32'h30);
      checkOutput("limpa_res_valid", {31'd0, bus.res_valid}, 32'd1);
      waitIdle();

      $display("[TB] backpressure");
      bus.res_ready = 1'b0;
      applyStimulus(3'b000, 8'h10, 8'h01, 1'b0, 8'h11);
      applyStimulus(3'b011, 8'h0F, 8'hF0, 1'b0, 8'hFF);
      applyStimulus(3'b100, 8'hAA, 8'hFF, 1'b0, 8'h55);
      applyStimulus(3'b110, 8'h81, 8'h00, 1'b0, 8'h02);
      applyStimulus(3'b111, 8'h81, 8'h00, 1'b0, 8'h40);
      checkOutput("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      checkOutput("bp_count", {29'd0, dut.u_fila.count_q}, 32'd4);
      checkOutput("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      checkOutput("bp_res_saida", {24'd0, bus.res_saida}, 32'h11);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", {31'd0, bus.res_valid}, 32'd1);
      checkOutput("bp_hold_saida", {24'd0, bus.res_saida}, 32'h11);
      checkOutput("bp_hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
      bus.res_ready = 1'b1;
      waitIdle();

      $display("[TB] wrap-around");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(w_cod[i], w_a[i], w_b[i], 1'b0, w_exp[i]);
      end
      waitIdle();
      checkOutput("wrap_count", {29'd0, dut.u_fila.count_q}, 32'd0);
      checkOutput("wrap_acumulador", {24'd0, acumulador}, 32'hFF);

      $display("[TB] reset mid-flight");
      applyStimulus(3'b000, 8'h01, 8'h01, 1'b0, 8'h02);
      applyStimulus(3'b000, 8'h02, 8'h02, 1'b0, 8'h04);
      applyStimulus(3'b000, 8'h03, 8'h03, 1'b0, 8'h06);
      @(posedge clk); #1;
      checkOutput("mid_estado", {30'd0, dut.estado_q}, {30'd0, calc_pkg::CALCULA});
      rst = 1'b1;
      #1;
      exp_q.delete();
      checkOutput("mid_res_valid", {31'd0, bus.res_valid}, 32'd0);
      checkOutput("mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      checkOutput("mid_acumulador", {24'd0, acumulador}, 32'd0);
      checkOutput("mid_count", {29'd0, dut.u_fila.count_q}, 32'd0);
      checkOutput("mid_ocupado", {31'd0, ocupado}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("mid_no_result", {31'd0, bus.res_valid}, 32'd0);
      checkOutput("mid_idle", {31'd0, ocupado}, 32'd0);

      checkOutput("pending_results", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
